alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- Operand-fetch stage that sits directly upstream of the 16-bit ALU (ALUK encoding: 00 ADD, 01 AND, 10 NOT A, 11 pass A).
- Decodes LC-3 ADD/AND/NOT instructions and reads the 8x16 register file.
- Registers A, B, ALUK and DR toward the ALU through a valid/ready handshake.
- Holds a per-register busy scoreboard, so an instruction waits until its sources have been written back by the downstream path.

Parameters:
- RESET_VAL, 16'h0000, value loaded into every register-file entry on reset.
- BYPASS, 1, 1 = a write-back in the same cycle as a source read forwards wb_data; 0 = stall one cycle instead.

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- in_valid  in  1  IR is presented
- in_ready  out  1  stage accepts IR this cycle
- IR  in  16  instruction word
- wb_en  in  1  register-file write strobe
- wb_dr  in  3  write destination
- wb_data  in  16  write data
- out_valid  out  1  A/B/ALUK/DR hold a valid operation
- out_ready  in  1  ALU side consumes the operation
- A  out  16  SR1 operand
- B  out  16  SR2 operand, sign-extended imm5, or 0
- ALUK  out  2  ALU function select
- DR  out  3  destination of the issued operation
- err_op  out  1  sticky: a non-ALU opcode was received

Behaviour:
- Reset (asynchronous, active-high):
  - R0..R7 = RESET_VAL; busy[7:0] = 0.
  - out_valid = 0; A = B = 0; ALUK = 00; DR = 0; err_op = 0.
  - Reset asserted mid-transfer discards the held operation and any pending busy bits.
- Decode:
  - IR[15:12] = 0001 -> ALUK 00; 0101 -> ALUK 01; 1001 -> ALUK 10.
  - DR = IR[11:9]; SR1 = IR[8:6].
  - ADD/AND with IR[5] = 1: B = sign-extend IR[4:0] to 16 bits, e.g. 5'b10000 -> 16'hFFF0.
  - ADD/AND with IR[5] = 0: B = R[IR[2:0]], and SR2 = IR[2:0] is a source.
  - NOT: B = 0 and SR2 is not a source.
- Hazard is asserted when any of these holds:
  - busy[SR1] is set;
  - SR2 is a source and busy[SR2] is set;
  - busy[DR] is set (WAW).
  - Exception: a busy source whose register is being written this cycle (wb_en && wb_dr == src) is not a hazard when BYPASS = 1.
- Handshake:
  - in_ready = (!out_valid || out_ready) && !(in_valid && ALU-opcode && hazard).
  - Accept when in_valid && in_ready. On the next edge the output register loads and out_valid = 1, giving 1-cycle latency from accept to out_valid.
  - If out_valid && out_ready and nothing is accepted, out_valid drops to 0 on the next edge.
  - A, B, ALUK and DR stay stable while out_valid && !out_ready.
  - Back-to-back throughput is 1 op/cycle when there are no hazards.
- Non-ALU opcodes:
  - Accepted whenever (!out_valid || out_ready).
  - Dropped without being issued; err_op is set.
  - err_op clears only on reset.
- Register file and scoreboard:
  - wb_en writes R[wb_dr] <= wb_data and clears busy[wb_dr].
  - Accepting an ALU op sets busy[DR].
  - If the same register is cleared and set in one cycle, set wins.
  - A write-back to a non-busy register is legal and only updates the data.
- Bypass:
  - With BYPASS = 1, a source read that matches an active wb_dr uses wb_data.
  - SR1 == SR2 == wb_dr forwards to both A and B.
- R0 is an ordinary register, with no hard-wired zero.

Optional Feature:
- Macro: ALU_OPSTAGE_DBG_EN.
- Defined:
  - Adds input dbg_sel[2:0] and output dbg_data[16] = {busy[dbg_sel] is not included}; dbg_data is R[dbg_sel], read combinationally without bypass.
  - Adds output stall_cnt[16]: increments every cycle in_valid && !in_ready, saturates at 16'hFFFF, and resets to 0.
- Undefined: these ports and logic are absent; the rest of the behaviour is identical.

Test Plan:
1. Reset, then wb R1 = 16'h0005 and R2 = 16'h0003; IR = 16'h1642 (ADD R3, R1, R2) -> one cycle later out_valid = 1, A = 0005, B = 0003, ALUK = 00, DR = 3.
2. IR = 16'h567F (AND R3, R1, #-1) with R1 = 16'h00F0 -> A = 00F0, B = FFFF, ALUK = 01; busy[3] = 1.
3. Issue ADD R3, then ADD R4, R3, R3 -> in_ready = 0 until wb_en with wb_dr = 3 and wb_data = 16'h0008. In that cycle, with BYPASS = 1, the op is accepted with A = B = 0008.
4. out_ready = 0 for 3 cycles with out_valid = 1 -> A, B, ALUK and DR are unchanged and in_ready = 0; out_ready = 1 -> the next op issues.
5. IR = 16'h987F (NOT R4, R1) with R1 = 16'h1234 -> A = 1234, B = 0000, ALUK = 10. Then IR = 16'h0E05 (BR) -> dropped, err_op = 1, out_valid unaffected.
6. Assert Reset while out_valid = 1 and busy[3] = 1 -> out_valid = 0, busy = 0, all registers = RESET_VAL, and err_op = 0 immediately without waiting for a clock edge.

Source files
------------

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage for the LC-3 ALU: decodes ADD/AND/NOT, reads the register file, tracks busy registers.
// Optional debug ports (dbg_sel, dbg_data, stall_cnt) are enabled by defining ALU_OPSTAGE_DBG_EN.
module alu_operand_stage #(
  parameter logic [15:0] RESET_VAL = 16'h0000,
  parameter int unsigned BYPASS    = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] IR,
  input  logic        wb_en,
  input  logic [2:0]  wb_dr,
  input  logic [15:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] A,
  output logic [15:0] B,
  output logic [1:0]  ALUK,
  output logic [2:0]  DR,
  output logic        err_op
`ifdef ALU_OPSTAGE_DBG_EN
  ,
  input  logic [2:0]  dbg_sel,
  output logic [15:0] dbg_data,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [3:0] {
    OP_ADD = 4'b0001,
    OP_AND = 4'b0101,
    OP_NOT = 4'b1001
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_AND  = 2'b01,
    ALU_NOT  = 2'b10,
    ALU_PASS = 2'b11
  } aluk_e;

  logic [15:0] rf_q [8];
  logic [15:0] rf_d [8];
  logic [7:0]  busy_q, busy_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [1:0]  aluk_q, aluk_d;
  logic [2:0]  dr_q, dr_d;
  logic        err_op_q, err_op_d;

  logic [3:0]  opc;
  logic        is_alu, is_not, sr2_src;
  logic [2:0]  dr_f, sr1, sr2;
  logic        wb_hit1, wb_hit2, haz1, haz2, hazard;
  logic        slot_free, ready, accept, issue;
  logic [15:0] rd1, rd2, b_val;
  logic [1:0]  aluk_val;

  always_comb begin
    opc     = IR[15:12];
    is_not  = (opc == OP_NOT);
    is_alu  = (opc == OP_ADD) || (opc == OP_AND) || is_not;
    dr_f    = IR[11:9];
    sr1     = IR[8:6];
    sr2     = IR[2:0];
    sr2_src = !is_not && !IR[5];
    wb_hit1 = wb_en && (wb_dr == sr1);
    wb_hit2 = wb_en && (wb_dr == sr2);

    // Without forwarding, any source being written this cycle waits for the registered value.
    if (BYPASS != 0) begin
      haz1 = busy_q[sr1] && !wb_hit1;
      haz2 = sr2_src && busy_q[sr2] && !wb_hit2;
    end else begin
      haz1 = busy_q[sr1] || wb_hit1;
      haz2 = sr2_src && (busy_q[sr2] || wb_hit2);
    end
    hazard = haz1 || haz2 || busy_q[dr_f];

    slot_free = !out_valid_q || out_ready;
    ready     = slot_free && !(in_valid && is_alu && hazard);
    accept    = in_valid && ready;
    issue     = accept && is_alu;

    rd1 = ((BYPASS != 0) && wb_hit1) ? wb_data : rf_q[sr1];
    rd2 = ((BYPASS != 0) && wb_hit2) ? wb_data : rf_q[sr2];

    if (is_not)     b_val = '0;
    else if (IR[5]) b_val = {{11{IR[4]}}, IR[4:0]};
    else            b_val = rd2;

    case (opc)
      OP_AND:  aluk_val = ALU_AND;
      OP_NOT:  aluk_val = ALU_NOT;
      default: aluk_val = ALU_ADD;
    endcase
  end

  always_comb begin
    out_valid_d = issue ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    a_d         = issue ? rd1      : a_q;
    b_d         = issue ? b_val    : b_q;
    aluk_d      = issue ? aluk_val : aluk_q;
    dr_d        = issue ? dr_f     : dr_q;
    err_op_d    = err_op_q || (accept && !is_alu);

    // Clear first, then set, so an issue to the register being written back keeps it busy.
    busy_d = busy_q;
    if (wb_en) busy_d[wb_dr] = 1'b0;
    if (issue) busy_d[dr_f]  = 1'b1;

    rf_d = rf_q;
    if (wb_en) rf_d[wb_dr] = wb_data;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < 8; i++) rf_q[i] <= RESET_VAL;
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      aluk_q      <= ALU_ADD;
      dr_q        <= '0;
      err_op_q    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 8; i++) rf_q[i] <= rf_d[i];
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      aluk_q      <= aluk_d;
      dr_q        <= dr_d;
      err_op_q    <= err_op_d;
    end
  end

  assign in_ready  = ready;
  assign out_valid = out_valid_q;
  assign A         = a_q;
  assign B         = b_q;
  assign ALUK      = aluk_q;
  assign DR        = dr_q;
  assign err_op    = err_op_q;

`ifdef ALU_OPSTAGE_DBG_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid && !ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign dbg_data  = rf_q[dbg_sel];
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: expected operations are queued when driven and compared when issued.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] ir;
  logic        wb_en;
  logic [2:0]  wb_dr;
  logic [15:0] wb_data;
  logic        out_valid, out_ready;
  logic [15:0] a, b;
  logic [1:0]  aluk;
  logic [2:0]  dr;
  logic        err_op;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  k;
    logic [2:0]  d;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .Clk      (clk),
    .Reset    (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .IR       (ir),
    .wb_en    (wb_en),
    .wb_dr    (wb_dr),
    .wb_data  (wb_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .A        (a),
    .B        (b),
    .ALUK     (aluk),
    .DR       (dr),
    .err_op   (err_op)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] ea, input logic [15:0] eb,
                          input logic [1:0] ek, input logic [2:0] ed);
    exp_t e;
    e.a = ea; e.b = eb; e.k = ek; e.d = ed;
    sb.push_back(e);
  endtask

  task automatic chk_out(input string name, input bit pop);
    exp_t e;
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=output expected=no_pending_entry", name);
    end else begin
      e = sb[0];
      if (pop) void'(sb.pop_front());
      chk(name, 64'({a, b, aluk, dr}), 64'(e));
    end
  endtask

  task automatic wb(input logic [2:0] d, input logic [15:0] v);
    wb_en = 1'b1; wb_dr = d; wb_data = v;
    tick();
    wb_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; ir = '0; wb_en = 1'b0; wb_dr = '0; wb_data = '0;
    out_ready = 1'b1;
    repeat (2) tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_regs", 64'({a, b, aluk, dr}), 64'd0);
    chk("rst_err", 64'(err_op), 64'd0);
    rst = 1'b0;
    tick();

    // ADD R3, R1, R2
    wb(3'd1, 16'h0005);
    wb(3'd2, 16'h0003);
    in_valid = 1'b1; ir = 16'h1642; settle();
    chk("t1_rdy", 64'(in_ready), 64'd1);
    push_exp(16'h0005, 16'h0003, 2'b00, 3'd3);
    tick(); in_valid = 1'b0;
    chk_out("t1_out", 1'b1);
    wb(3'd3, 16'h0000);
    chk("t1_drop", 64'(out_valid), 64'd0);
    wb(3'd1, 16'h00F0);

    // AND R3, R1, #-1
    in_valid = 1'b1; ir = 16'h567F; settle();
    chk("t2_rdy", 64'(in_ready), 64'd1);
    push_exp(16'h00F0, 16'hFFFF, 2'b01, 3'd3);
    tick(); in_valid = 1'b0;
    chk_out("t2_out", 1'b1);

    // ADD R4, R3, R3 waits on busy R3, then takes the forwarded write-back
    in_valid = 1'b1; ir = 16'h18C3; settle();
    chk("t3_stall0", 64'(in_ready), 64'd0);
    tick(); settle();
    chk("t3_stall1", 64'(in_ready), 64'd0);
    chk("t3_idle", 64'(out_valid), 64'd0);
    wb_en = 1'b1; wb_dr = 3'd3; wb_data = 16'h0008; settle();
    chk("t3_byp_rdy", 64'(in_ready), 64'd1);
    push_exp(16'h0008, 16'h0008, 2'b00, 3'd4);
    tick(); wb_en = 1'b0; in_valid = 1'b0;
    chk_out("t3_out", 1'b0);

    // Backpressure: held operation must not change
    out_ready = 1'b0; in_valid = 1'b1; ir = 16'h1A61;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t4_hold_rdy", 64'(in_ready), 64'd0);
      tick();
      chk_out("t4_hold", 1'b0);
    end
    out_ready = 1'b1; settle();
    chk("t4_rel_rdy", 64'(in_ready), 64'd1);
    void'(sb.pop_front());
    push_exp(16'h00F0, 16'h0001, 2'b00, 3'd5);
    tick(); in_valid = 1'b0;
    chk_out("t4_next", 1'b1);

    // NOT R4, R1 then a non-ALU opcode
    wb(3'd1, 16'h1234);
    wb(3'd4, 16'h0000);
    wb(3'd5, 16'h0000);
    in_valid = 1'b1; ir = 16'h987F; settle();
    chk("t5_rdy", 64'(in_ready), 64'd1);
    push_exp(16'h1234, 16'h0000, 2'b10, 3'd4);
    tick(); in_valid = 1'b0;
    chk_out("t5_not", 1'b1);
    chk("t5_err0", 64'(err_op), 64'd0);
    tick();
    chk("t5_idle", 64'(out_valid), 64'd0);
    in_valid = 1'b1; ir = 16'h0E05; settle();
    chk("t5_br_rdy", 64'(in_ready), 64'd1);
    tick(); in_valid = 1'b0;
    chk("t5_err", 64'(err_op), 64'd1);
    chk("t5_br_noissue", 64'(out_valid), 64'd0);
    tick();
    chk("t5_err_sticky", 64'(err_op), 64'd1);

    // ADD R6, R2, #-16 : most negative imm5
    in_valid = 1'b1; ir = 16'h1CB0; settle();
    chk("sext_rdy", 64'(in_ready), 64'd1);
    push_exp(16'h0003, 16'hFFF0, 2'b00, 3'd6);
    tick(); in_valid = 1'b0;
    chk_out("sext_out", 1'b1);

    // Consume and issue in the same cycle, then reset while held
    in_valid = 1'b1; ir = 16'h1642; settle();
    chk("t6_b2b_rdy", 64'(in_ready), 64'd1);
    push_exp(16'h1234, 16'h0003, 2'b00, 3'd3);
    tick(); in_valid = 1'b0; out_ready = 1'b0;
    chk_out("t6_pre", 1'b1);
    rst = 1'b1; #1;
    chk("t6_async_valid", 64'(out_valid), 64'd0);
    chk("t6_async_err", 64'(err_op), 64'd0);
    chk("t6_async_regs", 64'({a, b, aluk, dr}), 64'd0);
    sb.delete();
    tick();
    rst = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; ir = 16'h1642; settle();
    chk("t6_busy_clr", 64'(in_ready), 64'd1);
    push_exp(16'h0000, 16'h0000, 2'b00, 3'd3);
    tick(); in_valid = 1'b0;
    chk_out("t6_rf_reset", 1'b1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
